// File: rtl/spi_xfer_seq_pkg.sv
// ---------------------------------------------------------------------------
// spi_xfer_seq_pkg
//   Shared definitions for the SPI transfer sequencer:
//     - state_t        : per-byte program states
//     - ADDR_*         : SPI controller register map
//     - CTRL_*         : bit positions inside the controller CTRL register
//     - ctrl_word()    : builds the CTRL value that starts a master transfer
// ---------------------------------------------------------------------------
package spi_xfer_seq_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      CFG_DIV   = 3'd1,
      LOAD      = 3'd2,
      ENABLE    = 3'd3,
      WAIT_BUSY = 3'd4,
      WAIT_DONE = 3'd5,
      READ      = 3'd6,
      DISABLE   = 3'd7
   } state_t;

   localparam logic [7:0] ADDR_CTRL   = 8'h00;
   localparam logic [7:0] ADDR_STATUS = 8'h04;
   localparam logic [7:0] ADDR_TXDATA = 8'h08;
   localparam logic [7:0] ADDR_RXDATA = 8'h0C;
   localparam logic [7:0] ADDR_CLKDIV = 8'h10;

   localparam int CTRL_EN   = 0;
   localparam int CTRL_MODE = 1;
   localparam int CTRL_LSB  = 2;

   // Enable + master mode, with the requested bit order.
   function automatic logic [7:0] ctrl_word(input logic lsb_first);
      logic [7:0] w;
      w           = 8'h00;
      w[CTRL_EN]  = 1'b1;
      w[CTRL_MODE] = 1'b1;
      w[CTRL_LSB] = lsb_first;
      return w;
   endfunction

endpackage

// File: rtl/spi_xfer_seq_fifo.sv
// ---------------------------------------------------------------------------
// spi_xfer_seq_fifo
//   Synchronous FIFO holding TX bytes until the sequencer loads them.
//   Ports:
//     clk, reset_n   : clock, asynchronous active-low reset (empties FIFO)
//     push/push_data : write one entry (caller guarantees !full)
//     pop            : drop the head entry (caller guarantees !empty)
//     head           : current head entry
//     full, empty    : occupancy flags
// ---------------------------------------------------------------------------
module spi_xfer_seq_fifo #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic [DATA_W-1:0] head,
   output logic              full,
   output logic              empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   // One extra pointer bit distinguishes full from empty when indices match.
   logic [AW:0]       wr_ptr;
   logic [AW:0]       rd_ptr;
   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   // Storage carries data only; occupancy is defined by the pointers.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= push_data;
   end

   assign head  = mem[rd_ptr[AW-1:0]];
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/spi_xfer_seq.sv
// ---------------------------------------------------------------------------
// spi_xfer_seq
//   Byte-stream front end for the SPI controller. TX bytes are buffered in a
//   FIFO; for each byte the FSM runs a fixed register program on the
//   controller bus (CLKDIV, TXDATA, CTRL enable, wait, read RXDATA, CTRL
//   disable) and returns the received byte on a valid/ready stream.
//
//   The bus action belonging to a state is registered on entry to that state,
//   so spi_reg_* show that state's access for exactly the cycles it is active.
//
//   Optional feature macro: SPI_XFER_SEQ_TIMEOUT_EN
//     defined   : WAIT_BUSY / WAIT_DONE abort after TIMEOUT_CYCLES cycles,
//                 setting sticky err_timeout (cleared by err_clr).
//     undefined : waits are unbounded, err_timeout is 0, err_clr ignored.
//
//   Ports:
//     clk, reset_n            : clock, asynchronous active-low reset
//     cfg_clk_div, cfg_lsb_first : controller configuration
//     tx_valid/tx_data/tx_ready  : TX byte stream in
//     rx_valid/rx_data/rx_ready  : RX byte stream out
//     busy                    : program in progress
//     err_timeout, err_clr    : sticky timeout flag and its clear
//     spi_cs_n                : chip select, low for the whole program
//     spi_reg_addr/write/wdata/rdata : controller register bus
//     spi_ready               : controller transfer-ready status
// ---------------------------------------------------------------------------
module spi_xfer_seq
   import spi_xfer_seq_pkg::*;
#(
   parameter int FIFO_DEPTH     = 4,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [7:0] cfg_clk_div,
   input  logic       cfg_lsb_first,
   input  logic       tx_valid,
   input  logic [7:0] tx_data,
   output logic       tx_ready,
   output logic       rx_valid,
   output logic [7:0] rx_data,
   input  logic       rx_ready,
   output logic       busy,
   output logic       err_timeout,
   input  logic       err_clr,
   output logic       spi_cs_n,
   output logic [7:0] spi_reg_addr,
   output logic       spi_reg_write,
   output logic [7:0] spi_reg_wdata,
   input  logic [7:0] spi_reg_rdata,
   input  logic       spi_ready
);

   state_t     state;
   logic       fifo_full;
   logic       fifo_empty;
   logic [7:0] fifo_head;
   logic       fifo_push;
   logic       fifo_pop;

   assign tx_ready  = !fifo_full;
   assign fifo_push = tx_valid && tx_ready;
   assign fifo_pop  = (state == LOAD);

   spi_xfer_seq_fifo #(
      .DATA_W (8),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (fifo_push),
      .push_data (tx_data),
      .pop       (fifo_pop),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

`ifdef SPI_XFER_SEQ_TIMEOUT_EN
   localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

   logic [TW-1:0] tmo_cnt;
   logic          err_q;

   assign err_timeout = err_q;
`else
   logic unused_tmo_cfg;

   assign err_timeout    = 1'b0;
   assign unused_tmo_cfg = err_clr ^ (TIMEOUT_CYCLES > 0);
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state         <= IDLE;
         spi_cs_n      <= 1'b1;
         spi_reg_write <= 1'b0;
         spi_reg_addr  <= ADDR_STATUS;
         spi_reg_wdata <= 8'h00;
         rx_valid      <= 1'b0;
         rx_data       <= 8'h00;
         busy          <= 1'b0;
`ifdef SPI_XFER_SEQ_TIMEOUT_EN
         tmo_cnt       <= '0;
         err_q         <= 1'b0;
`endif
      end else begin
         spi_reg_write <= 1'b0;

         // Consumer handshake; READ below may reload in the same cycle.
         if (rx_valid && rx_ready) rx_valid <= 1'b0;

`ifdef SPI_XFER_SEQ_TIMEOUT_EN
         // A timeout assigned later in this block overrides the clear.
         if (err_clr) err_q <= 1'b0;
`endif

         case (state)
            IDLE: begin
               if (!fifo_empty) begin
                  state         <= CFG_DIV;
                  spi_cs_n      <= 1'b0;
                  busy          <= 1'b1;
                  spi_reg_addr  <= ADDR_CLKDIV;
                  spi_reg_wdata <= cfg_clk_div;
                  spi_reg_write <= 1'b1;
               end
            end
            CFG_DIV: begin
               state         <= LOAD;
               spi_reg_addr  <= ADDR_TXDATA;
               spi_reg_wdata <= fifo_head;
               spi_reg_write <= 1'b1;
            end
            LOAD: begin
               state         <= ENABLE;
               spi_reg_addr  <= ADDR_CTRL;
               spi_reg_wdata <= ctrl_word(cfg_lsb_first);
               spi_reg_write <= 1'b1;
            end
            ENABLE: begin
               state        <= WAIT_BUSY;
               spi_reg_addr <= ADDR_STATUS;
`ifdef SPI_XFER_SEQ_TIMEOUT_EN
               tmo_cnt      <= '0;
`endif
            end
            WAIT_BUSY: begin
               if (!spi_ready) begin
                  state <= WAIT_DONE;
`ifdef SPI_XFER_SEQ_TIMEOUT_EN
                  tmo_cnt <= '0;
               end else if (tmo_cnt == TMO_LAST) begin
                  err_q         <= 1'b1;
                  state         <= DISABLE;
                  spi_reg_addr  <= ADDR_CTRL;
                  spi_reg_wdata <= 8'h00;
                  spi_reg_write <= 1'b1;
               end else begin
                  tmo_cnt <= tmo_cnt + TW'(1);
`endif
               end
            end
            WAIT_DONE: begin
               if (spi_ready) begin
                  state        <= READ;
                  spi_reg_addr <= ADDR_RXDATA;
`ifdef SPI_XFER_SEQ_TIMEOUT_EN
               end else if (tmo_cnt == TMO_LAST) begin
                  err_q         <= 1'b1;
                  state         <= DISABLE;
                  spi_reg_addr  <= ADDR_CTRL;
                  spi_reg_wdata <= 8'h00;
                  spi_reg_write <= 1'b1;
               end else begin
                  tmo_cnt <= tmo_cnt + TW'(1);
`endif
               end
            end
            READ: begin
               // Stall here while the previous RX byte is still unclaimed.
               if (!rx_valid || rx_ready) begin
                  rx_data       <= spi_reg_rdata;
                  rx_valid      <= 1'b1;
                  state         <= DISABLE;
                  spi_reg_addr  <= ADDR_CTRL;
                  spi_reg_wdata <= 8'h00;
                  spi_reg_write <= 1'b1;
               end
            end
            DISABLE: begin
               state        <= IDLE;
               spi_cs_n     <= 1'b1;
               busy         <= 1'b0;
               spi_reg_addr <= ADDR_STATUS;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_xfer_seq.sv
module tb_spi_xfer_seq;

   logic       clk;
   logic       reset_n;
   logic [7:0] cfg_clk_div;
   logic       cfg_lsb_first;
   logic       tx_valid;
   logic [7:0] tx_data;
   logic       tx_ready;
   logic       rx_valid;
   logic [7:0] rx_data;
   logic       rx_ready;
   logic       busy;
   logic       err_timeout;
   logic       err_clr;
   logic       spi_cs_n;
   logic [7:0] spi_reg_addr;
   logic       spi_reg_write;
   logic [7:0] spi_reg_wdata;
   logic [7:0] spi_reg_rdata;
   logic       spi_ready;

   int n_assert = 0;
   int n_fail   = 0;

   // Controller model state
   logic       stuck;
   logic [7:0] rx_byte;
   int         ph;
   int         mcnt;
   int         cyc;
   int         cs_bad;

   logic [15:0] wlog[$];
   int          wcyc[$];
   logic [7:0]  rxq[$];

   spi_xfer_seq #(
      .FIFO_DEPTH     (4),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .cfg_clk_div   (cfg_clk_div),
      .cfg_lsb_first (cfg_lsb_first),
      .tx_valid      (tx_valid),
      .tx_data       (tx_data),
      .tx_ready      (tx_ready),
      .rx_valid      (rx_valid),
      .rx_data       (rx_data),
      .rx_ready      (rx_ready),
      .busy          (busy),
      .err_timeout   (err_timeout),
      .err_clr       (err_clr),
      .spi_cs_n      (spi_cs_n),
      .spi_reg_addr  (spi_reg_addr),
      .spi_reg_write (spi_reg_write),
      .spi_reg_wdata (spi_reg_wdata),
      .spi_reg_rdata (spi_reg_rdata),
      .spi_ready     (spi_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Controller returns the byte it was loaded with XOR 0x99.
   assign spi_reg_rdata = (spi_reg_addr == 8'h0C) ? rx_byte :
                          (spi_reg_addr == 8'h04) ? {7'b0, spi_ready} : 8'h00;

   always @(posedge clk) begin
      cyc++;
      if (!reset_n) begin
         ph = 0;
         mcnt = 0;
         spi_ready <= 1'b1;
      end else begin
         if (spi_reg_write) begin
            wlog.push_back({spi_reg_addr, spi_reg_wdata});
            wcyc.push_back(cyc);
            if (spi_reg_addr == 8'h08) rx_byte = spi_reg_wdata ^ 8'h99;
         end
         if (rx_valid && rx_ready) rxq.push_back(rx_data);
         if ((spi_reg_write && spi_cs_n) || (busy == spi_cs_n)) cs_bad++;
         case (ph)
            0: if (spi_reg_write && spi_reg_addr == 8'h00 && spi_reg_wdata[0] && !stuck) begin
                  ph = 1;
                  mcnt = 0;
               end
            1: begin
                  mcnt++;
                  if (mcnt == 3) begin
                     spi_ready <= 1'b0;
                     ph = 2;
                     mcnt = 0;
                  end
               end
            default: begin
                  mcnt++;
                  if (mcnt == 20) begin
                     spi_ready <= 1'b1;
                     ph = 0;
                  end
               end
         endcase
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] wget(input int i);
      if (i < wlog.size()) return wlog[i];
      return 16'hDEAD;
   endfunction

   function automatic logic [7:0] rget(input int i);
      if (i < rxq.size()) return rxq[i];
      return 8'hEE;
   endfunction

   task automatic push_byte(input logic [7:0] b, input bit last);
      @(negedge clk);
      tx_valid = 1'b1;
      tx_data  = b;
      for (int i = 0; i < 200 && !tx_ready; i++) @(negedge clk);
      chk("push_tx_ready", tx_ready, 1'b1);
      @(posedge clk);
      #1;
      if (last) tx_valid = 1'b0;
   endtask

   task automatic wait_rx(input string tag);
      for (int i = 0; i < 300 && !rx_valid; i++) @(negedge clk);
      chk(tag, rx_valid, 1'b1);
   endtask

   task automatic wait_idle(input string tag);
      int streak;
      int i;
      streak = 0;
      for (i = 0; i < 20 && !busy; i++) @(negedge clk);
      for (i = 0; i < 1000 && streak < 4; i++) begin
         @(negedge clk);
         streak = busy ? 0 : streak + 1;
      end
      chk(tag, (streak >= 4), 1'b1);
   endtask

   logic [7:0] burst [5];
   logic [7:0] txw [$];

   initial begin
      reset_n       = 1'b0;
      cfg_clk_div   = 8'h00;
      cfg_lsb_first = 1'b0;
      tx_valid      = 1'b0;
      tx_data       = 8'h00;
      rx_ready      = 1'b0;
      err_clr       = 1'b0;
      stuck         = 1'b0;
      rx_byte       = 8'h00;
      cs_bad        = 0;

      // Reset values
      repeat (2) @(negedge clk);
      chk("rst_tx_ready", tx_ready, 1'b1);
      chk("rst_rx_valid", rx_valid, 1'b0);
      chk("rst_rx_data", rx_data, 8'h00);
      chk("rst_busy", busy, 1'b0);
      chk("rst_err", err_timeout, 1'b0);
      chk("rst_cs_n", spi_cs_n, 1'b1);
      chk("rst_write", spi_reg_write, 1'b0);
      chk("rst_addr", spi_reg_addr, 8'h04);
      chk("rst_wdata", spi_reg_wdata, 8'h00);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      // Single byte, RX held by consumer
      wlog.delete(); wcyc.delete(); cs_bad = 0;
      cfg_clk_div = 8'h02;
      push_byte(8'hA5, 1'b1);
      wait_rx("t1_rx_valid");
      chk("t1_rx_data", rx_data, 8'h3C);
      wait_idle("t1_idle");
      chk("t1_nwrites", wlog.size(), 4);
      chk("t1_w0", wget(0), 16'h1002);
      chk("t1_w1", wget(1), 16'h08A5);
      chk("t1_w2", wget(2), 16'h0003);
      chk("t1_w3", wget(3), 16'h0000);
      chk("t1_cs_bad", cs_bad, 0);
      chk("t1_rx_hold", rx_data, 8'h3C);
      rx_ready = 1'b1;
      @(negedge clk);
      chk("t1_rx_consumed", rx_valid, 1'b0);

      // LSB-first control word
      wlog.delete(); rxq.delete();
      cfg_lsb_first = 1'b1;
      push_byte(8'h81, 1'b1);
      wait_idle("t2_idle");
      chk("t2_ctrl", wget(2), 16'h0007);
      chk("t2_nrx", rxq.size(), 1);
      chk("t2_rx0", rget(0), 8'h18);
      cfg_lsb_first = 1'b0;

      // Back-to-back burst overfilling the FIFO
      wlog.delete(); rxq.delete();
      burst[0] = 8'h10; burst[1] = 8'h20; burst[2] = 8'h30; burst[3] = 8'h40; burst[4] = 8'h50;
      for (int k = 0; k < 5; k++) push_byte(burst[k], k == 4);
      @(negedge clk);
      chk("t3_full", tx_ready, 1'b0);
      wait_idle("t3_idle");
      txw.delete();
      for (int k = 0; k < wlog.size(); k++)
         if (wlog[k][15:8] == 8'h08) txw.push_back(wlog[k][7:0]);
      chk("t3_ntx", txw.size(), 5);
      chk("t3_nrx", rxq.size(), 5);
      for (int k = 0; k < 5; k++) begin
         chk($sformatf("t3_tx%0d", k), (k < txw.size()) ? txw[k] : 8'hEE, burst[k]);
         chk($sformatf("t3_rx%0d", k), rget(k), burst[k] ^ 8'h99);
      end

      // RX back-pressure across two transfers
      rx_ready = 1'b0;
      push_byte(8'h11, 1'b0);
      push_byte(8'h22, 1'b1);
      wait_rx("t4_rx_valid");
      chk("t4_rx_first", rx_data, 8'h88);
      repeat (60) @(negedge clk);
      chk("t4_rx_stable", rx_data, 8'h88);
      chk("t4_rx_held", rx_valid, 1'b1);
      chk("t4_stall_busy", busy, 1'b1);
      chk("t4_stall_addr", spi_reg_addr, 8'h0C);
      rx_ready = 1'b1;
      @(negedge clk);
      chk("t4_rx_second_vld", rx_valid, 1'b1);
      chk("t4_rx_second", rx_data, 8'hBB);
      @(negedge clk);
      chk("t4_rx_drained", rx_valid, 1'b0);
      wait_idle("t4_idle");

`ifdef SPI_XFER_SEQ_TIMEOUT_EN
      // Controller never goes busy
      wlog.delete(); wcyc.delete(); rxq.delete();
      stuck = 1'b1;
      push_byte(8'h55, 1'b1);
      wait_idle("t5_idle");
      chk("t5_err", err_timeout, 1'b1);
      chk("t5_nwrites", wlog.size(), 4);
      chk("t5_disable", wget(3), 16'h0000);
      chk("t5_wait_len", (wcyc.size() >= 4) ? (wcyc[3] - wcyc[2]) : 0, 17);
      chk("t5_nrx", rxq.size(), 0);
      chk("t5_rx_valid", rx_valid, 1'b0);
      @(negedge clk); err_clr = 1'b1;
      @(negedge clk); err_clr = 1'b0;
      chk("t5_err_clr", err_timeout, 1'b0);
      stuck = 1'b0;
`endif

      // Asynchronous reset during WAIT_DONE
      push_byte(8'h66, 1'b0);
      push_byte(8'h77, 1'b0);
      push_byte(8'h88, 1'b1);
      for (int i = 0; i < 100 && spi_ready; i++) @(negedge clk);
      repeat (3) @(negedge clk);
      chk("t6_in_wait", busy, 1'b1);
      #2 reset_n = 1'b0;
      #1;
      chk("t6_cs_n", spi_cs_n, 1'b1);
      chk("t6_busy", busy, 1'b0);
      chk("t6_tx_ready", tx_ready, 1'b1);
      chk("t6_addr", spi_reg_addr, 8'h04);
      chk("t6_write", spi_reg_write, 1'b0);
      chk("t6_wdata", spi_reg_wdata, 8'h00);
      chk("t6_rx_valid", rx_valid, 1'b0);
      chk("t6_rx_data", rx_data, 8'h00);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (6) @(negedge clk);
      chk("t6_fifo_empty", busy, 1'b0);
      chk("t6_cs_idle", spi_cs_n, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
